// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//
// Exhaustively exercises a 2-input combinational gate. Each of the four
// input vectors {a,b} = 00, 01, 10, 11 is held for SETTLE clock cycles, then
// the gate output y is compared against EXPECTED[{a,b}]. Results are
// accumulated into an error count and a per-vector fail mask.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request a full truth-table run (honoured in IDLE/DONE)
//   y          in   output of the gate under test
//   a, b       out  stimulus to the gate under test
//   busy       out  run in progress
//   done       out  level, run finished and results valid
//   pass       out  done with zero mismatches
//   err_count  out  mismatching vectors in the current/last run (0..4)
//   fail_mask  out  bit {a,b} set when that vector mismatched
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | stepping through the four vectors, sampling y after settling
// DONE  | results held stable until the next start or reset

module gate_tt_checker #(
    parameter logic [3:0] EXPECTED = 4'b1001,
    parameter int         SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter is compared before it increments, so the sample edge is
    // the one on which it would reach SETTLE.
    localparam logic [3:0] SAMPLE_AT = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] err_nxt;
    logic [3:0] mask_nxt;
    logic       sample;
    logic       mismatch;

    assign sample   = (cnt == SAMPLE_AT);
    assign mismatch = (y != EXPECTED[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            err_count <= err_nxt;
            fail_mask <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        mask_nxt  = fail_mask;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = 4'd0;
                    err_nxt   = 3'd0;
                    mask_nxt  = 4'd0;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 4'd1;
                if (sample) begin
                    if (mismatch) begin
                        if (err_count < 3'd4) begin
                            err_nxt = err_count + 3'd1;
                        end
                        mask_nxt[idx] = 1'b1;
                    end
                    cnt_nxt = 4'd0;
                    if (idx == 2'd3) begin
                        // idx stays at 3 so the last vector is held in DONE.
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The stimulus is the index register itself, so a/b are registered.
    assign a    = idx[1];
    assign b    = idx[0];
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_tt_checker.sv
module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       y;
    logic       a, b, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    logic       start1 = 1'b0;
    logic       y1;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err_count1;
    logic [3:0] fail_mask1;

    logic [1:0] mode = 2'd0;   // 0 xnor, 1 tied low, 2 xor
    int         cyc = 0;
    int         start_cycle = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [2:0] err;
        logic [3:0] mask;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic done_q = 1'b0;

    gate_tt_checker #(.EXPECTED(4'b1001), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .y(y),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask)
    );

    gate_tt_checker #(.EXPECTED(4'b1001), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_mask(fail_mask1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (mode)
            2'd1:    y = 1'b0;
            2'd2:    y = a ^ b;
            default: y = ~(a ^ b);
        endcase
    end
    assign y1 = ~(a1 ^ b1);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: each rising edge of done consumes one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - start_cycle, e.lat);
                    chk("err_count", int'(err_count), int'(e.err));
                    chk("fail_mask", int'(fail_mask), int'(e.mask));
                    chk("pass", int'(pass), int'(e.pass));
                    chk("busy_at_done", int'(busy), 0);
                end
            end
            done_q = done;
        end
    end

    task automatic run(input logic [1:0] m, input bit repulse,
                       input logic [2:0] e_err, input logic [3:0] e_mask);
        exp_t x;
        int n;
        mode = m;
        x.err = e_err; x.mask = e_mask; x.pass = (e_err == 3'd0); x.lat = 8;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b1;
        start_cycle = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        chk("done_after_start", int'(done), 0);
        chk("err_cleared", int'(err_count), 0);
        chk("mask_cleared", int'(fail_mask), 0);
        for (int g = 0; g < 20 && !done; g++) begin
            n = cyc - start_cycle;
            chk("ab_step", int'({a, b}), n / 2);
            if (repulse) start = (n == 2);
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            chk("done_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            chk("ab_hold_11", int'({a, b}), 3);
        end
        @(negedge clk);
    endtask

    initial begin
        int t1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ab", int'({a, b}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_mask", int'(fail_mask), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", int'(busy), 0);

        // Clean XNOR run, then results must hold in DONE.
        run(2'd0, 1'b0, 3'd0, 4'b0000);
        repeat (5) @(negedge clk);
        chk("done_hold", int'(done), 1);
        chk("pass_hold", int'(pass), 1);
        chk("err_hold", int'(err_count), 0);

        // y stuck at 0: vectors 00 and 11 mismatch.
        run(2'd1, 1'b0, 3'd2, 4'b1001);
        repeat (3) @(negedge clk);
        chk("fail_hold_mask", int'(fail_mask), 9);
        chk("fail_hold_pass", int'(pass), 0);

        // Restart from DONE with correct model clears counts.
        run(2'd0, 1'b0, 3'd0, 4'b0000);

        // XOR: every vector mismatches.
        run(2'd2, 1'b0, 3'd4, 4'b1111);

        // start re-pulsed at E0+3 is ignored.
        run(2'd0, 1'b1, 3'd0, 4'b0000);

        // Reset at E0+5 aborts the run.
        mode = 2'd2;
        @(negedge clk);
        start = 1'b1;
        start_cycle = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc - start_cycle < 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ab", int'({a, b}), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err_count), 0);
        chk("midrst_mask", int'(fail_mask), 0);
        rst = 1'b0;
        run(2'd0, 1'b0, 3'd0, 4'b0000);

        // rst wins over start on the same edge.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_prio_busy", int'(busy), 0);
        chk("rst_prio_done", int'(done), 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_prio_idle", int'(busy), 0);

        // SETTLE=1 instance completes four edges after start.
        @(negedge clk);
        start1 = 1'b1;
        t1 = cyc + 1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int g = 0; g < 12 && !done1; g++) @(negedge clk);
        chk("s1_done", int'(done1), 1);
        chk("s1_latency", cyc - t1, 4);
        chk("s1_pass", int'(pass1), 1);
        chk("s1_ab", int'({a1, b1}), 3);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
